// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: op encoding, FSM state, widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  // Word-address width of the instruction memory port.
  localparam int IMEM_AWIDTH = 11;

  // Memory op encoding.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LH   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SB   = 3'd4;
  localparam logic [2:0] OP_SH   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // Response-owner FSM state.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RESP_IF = 2'd1;
  localparam state_t ST_RESP_LS = 2'd2;

  // A load/store op that actually touches memory (NOP and the reserved code do not).
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_prio_sel.sv
// Two-way priority select: load/store beats fetch unless the fetch starvation override is set.
// Latency: purely combinational, zero cycles.
// Backpressure: the losing requester simply sees no win and must hold its request.
// Ports: i_if_vld / i_ls_vld - qualified requests; i_force_if - starvation override;
//        o_if_win / o_ls_win - one-hot-or-zero winner.
module mem_prio_sel (
  input  logic i_if_vld,
  input  logic i_ls_vld,
  input  logic i_force_if,
  output logic o_if_win,
  output logic o_ls_win
);

  // The override only matters when fetch is actually asking; otherwise ls still wins.
  assign o_if_win = i_if_vld & (~i_ls_vld | i_force_if);
  assign o_ls_win = i_ls_vld & ~(i_if_vld & i_force_if);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port, with a starvation guard for fetch.
// Latency: grant combinational in the request cycle; response exactly 1 cycle after issue.
// Backpressure: a requester without grant holds its request; no grant -> memory stalled.
// Ports: clk/nrst; if_req/if_addr -> if_gnt, if_rvalid/if_rdata;
//        ls_req/ls_op/ls_addr/ls_wdata -> ls_gnt, ls_rvalid/ls_rdata;
//        mem_stall/mem_op/mem_addr/mem_wdata to memory, mem_rdata back.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_Width = IMEM_AWIDTH,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  if_req,
  input  logic [ADDR_Width-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  ls_req,
  input  logic [2:0]            ls_op,
  input  logic [ADDR_Width-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [31:0]           ls_rdata,
  output logic                  mem_stall,
  output logic [2:0]            mem_op,
  output logic [ADDR_Width-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic          w_if_vld;
  logic          w_ls_vld;
  logic          w_force_if;
  logic          w_if_win;
  logic          w_ls_win;
  logic [CW-1:0] r_starve_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ls_store;

  // Requests are masked while reset is held so nothing is issued during reset.
  assign w_if_vld   = nrst & if_req;
  assign w_ls_vld   = nrst & ls_req & op_is_valid(ls_op);
  assign w_force_if = (r_starve_cnt == CW'(STARVE_MAX));

  mem_prio_sel u_prio_sel (
    .i_if_vld   (w_if_vld),
    .i_ls_vld   (w_ls_vld),
    .i_force_if (w_force_if),
    .o_if_win   (w_if_win),
    .o_ls_win   (w_ls_win)
  );

  assign if_gnt = w_if_win;
  assign ls_gnt = w_ls_win;

  // Memory command mux; idle cycles stall memory so its rdata is held.
  always_comb begin
    mem_stall = 1'b1;
    mem_op    = OP_NOP;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_win) begin
      mem_stall = 1'b0;
      mem_op    = OP_LW;
      mem_addr  = if_addr;
    end else if (w_ls_win) begin
      mem_stall = 1'b0;
      mem_op    = ls_op;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  // Counts consecutive cycles where fetch asked but load/store took the port.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_if_win) begin
      r_starve_cnt <= '0;
    end else if (w_ls_win && (r_starve_cnt != CW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Response owner is simply whoever was granted last cycle.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_if_win)      w_state_nxt = ST_RESP_IF;
    else if (w_ls_win) w_state_nxt = ST_RESP_LS;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_ls_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ls_win) r_ls_store <= op_is_store(ls_op);
    end
  end

  assign if_rvalid = (r_state == ST_RESP_IF);
  assign ls_rvalid = (r_state == ST_RESP_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  // A store response is only a completion ack; its data bus stays zero.
  assign ls_rdata  = (ls_rvalid && !r_ls_store) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 11;

  logic          clk;
  logic          nrst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          ls_req;
  logic [2:0]    ls_op;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic          mem_stall;
  logic [2:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_pass;
  int n_total;
  int n_fail;

  mem_arbiter #(.ADDR_Width(AW), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_op     (ls_op),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_stall (mem_stall),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: registered read, held while stalled.
  initial mem_rdata = 32'd0;
  always @(posedge clk) begin
    if (!mem_stall) begin
      if (mem_op == 3'd3) mem_rdata <= 32'h5A00_0000 + 32'(mem_addr);
      else                mem_rdata <= 32'hA5FA_115A;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    nrst = 1'b0;
    if_req = 1'b1; if_addr = 11'h010;
    ls_req = 1'b0; ls_op = 3'd0; ls_addr = '0; ls_wdata = 32'd0;
    #2;
    // Reset state, with a fetch request that must not be granted.
    chk("rst_if_gnt",    32'(if_gnt),    32'd0);
    chk("rst_ls_gnt",    32'(ls_gnt),    32'd0);
    chk("rst_stall",     32'(mem_stall), 32'd1);
    chk("rst_mem_op",    32'(mem_op),    32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_ls_rdata",  ls_rdata,       32'd0);
    chk("rst_starve",    32'(dut.r_starve_cnt), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

    // Fetch only.
    cyc();
    if_req = 1'b1; if_addr = 11'h010;
    #1;
    chk("f_if_gnt",   32'(if_gnt),    32'd1);
    chk("f_ls_gnt",   32'(ls_gnt),    32'd0);
    chk("f_mem_op",   32'(mem_op),    32'd3);
    chk("f_mem_addr", 32'(mem_addr),  32'h010);
    chk("f_stall",    32'(mem_stall), 32'd0);
    chk("f_wdata",    mem_wdata,      32'd0);

    // Fetch response; both request with LW.
    cyc();
    chk("f_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("f_if_rdata",  if_rdata,       32'h5A00_0010);
    chk("f_ls_rvalid", 32'(ls_rvalid), 32'd0);
    if_addr = 11'h030;
    ls_req = 1'b1; ls_op = 3'd3; ls_addr = 11'h020;
    #1;
    chk("b_ls_gnt",   32'(ls_gnt),   32'd1);
    chk("b_if_gnt",   32'(if_gnt),   32'd0);
    chk("b_mem_addr", 32'(mem_addr), 32'h020);

    // LS load response; everything idle.
    cyc();
    chk("b_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("b_ls_rdata",  ls_rdata,       32'h5A00_0020);
    chk("b_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("b_if_rdata",  if_rdata,       32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd1);
    chk("idle_addr",  32'(mem_addr),  32'd0);

    // Starvation: both held 4 cycles, ls wins 3 times then fetch is forced.
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i > 0) begin
        chk("s_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("s_ls_rdata",  ls_rdata,       32'h5A00_0040);
      end
      if_req = 1'b1; if_addr = 11'h100;
      ls_req = 1'b1; ls_op = 3'd3; ls_addr = 11'h040;
      #1;
      chk("s_starve", 32'(dut.r_starve_cnt), 32'(i));
      chk("s_if_gnt", 32'(if_gnt), (i == 3) ? 32'd1 : 32'd0);
      chk("s_ls_gnt", 32'(ls_gnt), (i == 3) ? 32'd0 : 32'd1);
    end

    // Forced-fetch response; store issue.
    cyc();
    chk("s_if_rvalid",  32'(if_rvalid), 32'd1);
    chk("s_if_rdata",   if_rdata,       32'h5A00_0100);
    chk("s_starve_end", 32'(dut.r_starve_cnt), 32'd0);
    if_req = 1'b0;
    ls_req = 1'b1; ls_op = 3'd6; ls_addr = 11'h055; ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("sw_ls_gnt", 32'(ls_gnt),   32'd1);
    chk("sw_mem_op", 32'(mem_op),   32'd6);
    chk("sw_addr",   32'(mem_addr), 32'h055);
    chk("sw_wdata",  mem_wdata,     32'hDEAD_BEEF);

    // Store ack carries zero data; NOP and code 7 are not requests.
    cyc();
    chk("sw_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("sw_ls_rdata",  ls_rdata,       32'd0);
    ls_op = 3'd0; ls_wdata = 32'd0;
    #1;
    chk("nop_ls_gnt", 32'(ls_gnt),    32'd0);
    chk("nop_if_gnt", 32'(if_gnt),    32'd0);
    chk("nop_stall",  32'(mem_stall), 32'd1);
    chk("nop_mem_op", 32'(mem_op),    32'd0);
    ls_op = 3'd7;
    #1;
    chk("op7_ls_gnt", 32'(ls_gnt),    32'd0);
    chk("op7_stall",  32'(mem_stall), 32'd1);

    // No response after an idle cycle; then a byte load.
    cyc();
    chk("nop_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("nop_ls_rdata",  ls_rdata,       32'd0);
    ls_op = 3'd1; ls_addr = 11'h007;
    #1;
    chk("lb_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("lb_mem_op", 32'(mem_op), 32'd1);

    cyc();
    chk("lb_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("lb_ls_rdata",  ls_rdata,       32'hA5FA_115A);
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 11'h010;
    #1;
    chk("r_if_gnt", 32'(if_gnt), 32'd1);

    // Reset pulsed while the fetch response is in flight.
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b1; ls_op = 3'd3; ls_addr = 11'h020;
    nrst = 1'b0;
    #1;
    chk("r_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("r_if_rdata",  if_rdata,       32'd0);
    chk("r_ls_gnt",    32'(ls_gnt),    32'd0);
    chk("r_stall",     32'(mem_stall), 32'd1);
    ls_req = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    chk("rel_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rel_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rel_mem_op",    32'(mem_op),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_Width, default 11, word-address width of the shared memory port.
REQ-002 Parameter STARVE_MAX, default 3, number of consecutive fetch denials before fetch is forced to win.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch read request.
REQ-006 if_addr  in  ADDR_Width  fetch word address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch data valid.
REQ-009 if_rdata  out  32  fetch data.
REQ-010 ls_req  in  1  load/store request.
REQ-011 ls_op  in  3  op code (package encoding).
REQ-012 ls_addr  in  ADDR_Width  load/store word address.
REQ-013 ls_wdata  in  32  store data.
REQ-014 ls_gnt  out  1  load/store request accepted this cycle.
REQ-015 ls_rvalid  out  1  load data valid, or store completion ack.
REQ-016 ls_rdata  out  32  load data.
REQ-017 mem_stall  out  1  memory hold; high freezes memory rdata.
REQ-018 mem_op  out  3  op code issued to memory.
REQ-019 mem_addr  out  ADDR_Width  address issued to memory.
REQ-020 mem_wdata  out  32  store data issued to memory.
REQ-021 mem_rdata  in  32  memory data, registered, valid the cycle after an unstalled issue.

Function
REQ-022 A load/store request is valid only if ls_req=1 and ls_op is in {LB,LH,LW,SB,SH,SW}; NOP or code 7 counts as no request.
REQ-023 At most one grant per cycle; if_gnt and ls_gnt are combinational and never both high.
REQ-024 Priority: load/store beats fetch, except when starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-025 starve_cnt (saturating, width clog2(STARVE_MAX+1)): +1 when if_req=1 and ls wins; cleared on if_gnt or when if_req=0.
REQ-026 Fetch grant drives mem_op=LW, mem_addr=if_addr, mem_wdata=0, mem_stall=0.
REQ-027 LS grant drives mem_op=ls_op, mem_addr=ls_addr, mem_wdata=ls_wdata, mem_stall=0.
REQ-028 No grant: mem_stall=1, mem_op=NOP, mem_addr=0, mem_wdata=0.
REQ-029 Response-owner FSM, states IDLE, RESP_IF, RESP_LS; next state = RESP_IF on if_gnt, RESP_LS on ls_gnt, otherwise IDLE, regardless of current state.
REQ-030 In RESP_IF: if_rvalid=1 and if_rdata=mem_rdata. In RESP_LS: ls_rvalid=1 and ls_rdata=mem_rdata (ls_rdata=0 for stores).
REQ-031 Issue-to-response latency is exactly 1 cycle; back-to-back grants give one response per cycle with no bubble.
REQ-032 rvalid outputs are 0 in IDLE; rdata outputs are 0 whenever their rvalid is 0.
REQ-033 The stored op in the LS path distinguishes a load from a store for REQ-030.

Reset
REQ-034 While nrst=0: FSM=IDLE, starve_cnt=0, all rvalid/rdata=0, no grants, mem_stall=1, mem_op=NOP.
REQ-035 Reset asserted mid-operation discards any in-flight response; no rvalid is produced in the first cycle after release.

Structure
REQ-036 Shared package mem_pkg holds the op encoding (NOP=0, LB=1, LH=2, LW=3, SB=4, SH=5, SW=6), FSM state typedef, and IMEM_AWIDTH=11.
REQ-037 One sub-module, mem_prio_sel: combinational two-way priority select with starvation override; the FSM and counters stay in mem_arbiter.

Verification
REQ-038 The bench memory model returns 0x5A000000+addr for LW and 0xA5FA115A for any other unstalled op, and holds rdata while stalled.
REQ-039 Fetch only, if_addr=0x010 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x5A000010.
REQ-040 Both request, ls_op=LW, ls_addr=0x020 -> ls_gnt=1, if_gnt=0; next cycle ls_rdata=0x5A000020, if_rvalid=0.
REQ-041 ls_req held with LW and if_req held for 4 cycles -> ls wins cycles 0-2, if_gnt in cycle 3, starve_cnt=0 afterwards.
REQ-042 ls_op=SW, ls_wdata=0xDEADBEEF -> mem_op=SW, mem_wdata=0xDEADBEEF; next cycle ls_rvalid=1, ls_rdata=0.
REQ-043 ls_req=1 with ls_op=NOP and if_req=0 -> no grant, mem_stall=1; nrst pulsed the cycle after a grant -> no rvalid after release.
